data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-organised data memory that answers load/store requests issued by the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It holds one transaction in flight, inserts a configurable number of wait states before responding, and applies byte-enable masking on writes. It is the responder end of the CPU data-memory interface. It lets the core and its benches exercise stall-tolerant memory handshakes instead of a zero-latency array.

## Interface
- DEPTH, 256: number of 32-bit words; a power of two ≥ 4.
- ADDR_W, 32: width of the byte address.
- WAIT_CYCLES, 2: wait states between request acceptance and the response; 0 is legal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  byte enables; bit i gates lane [8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  CPU takes the response.
- rsp_rdata  out  32  load data; full word, lanes not shifted; 0 for stores.
- rsp_err  out  1  access faulted (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state: IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch we/addr/wdata/be into request registers.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or to RESP directly when WAIT_CYCLES == 0.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1, execute the access and go to RESP.
- Access:
  - Word index = latched addr[log2(DEPTH)+1:2].
  - Store writes only the lanes whose be bit is set.
  - Load registers mem[index] into rsp_rdata.
  - be is ignored on loads.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE and clear rsp_valid.
- Only one transaction is outstanding. There is no request/response overlap.
- Request inputs are ignored outside IDLE.
- Memory contents are not reset and survive an assertion of rst.

## Timing
- Reset values, applied asynchronously while rst is low:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - State = IDLE, counter = 0.
- req_ready rises combinationally in IDLE once rst is high.
- Latency: rsp_valid rises on the (WAIT_CYCLES+1)th rising edge after the accepting edge.
- Store data is visible to a load accepted any time after the store's RESP.
- rsp_ready held high in RESP: RESP lasts exactly one cycle, and IDLE follows on the next cycle.
- Minimum spacing between accepted requests: WAIT_CYCLES + 2 cycles.
- rsp_ready low: the response is held indefinitely with no change to outputs.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is dropped and no response is produced.
  - A store whose access edge had not yet occurred leaves memory untouched.
- Addresses wrap modulo DEPTH words when error checking is compiled out.

## Configuration
- Macro: DMEM_ERR_CHECK_EN.
- Defined, a request faults when addr[1:0] != 0 or the word index ≥ DEPTH (upper address bits nonzero). A faulting request:
  - Writes nothing to memory.
  - Returns rsp_rdata = 0 and rsp_err = 1.
  - Still observes the normal wait-state latency and handshake.
- Undefined:
  - rsp_err is tied to 0.
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so the access wraps.

## Test plan
- Full-word store then load, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to 0x10, be = 0xF, then load 0x10.
  - Required: rsp_rdata = 0xDEADBEEF, and rsp_valid exactly 3 edges after each accept.
- Byte enables:
  - Store 0x11223344 to 0x20 with be = 0xF, then store 0xAABBCCDD with be = 0x5, then load.
  - Required: 0x11BB33DD.
- Backpressure:
  - Load with rsp_ready held low for 5 cycles.
  - Required: rsp_valid and rsp_rdata stable throughout, req_ready = 0 throughout, IDLE one cycle after rsp_ready rises.
- Zero wait states, WAIT_CYCLES = 0:
  - Back-to-back loads with rsp_ready tied high.
  - Required: rsp_valid one edge after each accept, and accepts spaced 2 cycles apart.
- Reset mid-store:
  - Assert rst during WAIT of a store of 0x12345678 to 0x40, then release rst and load 0x40.
  - Required: prior contents are returned, rsp_valid = 0 during reset, req_ready = 0 during reset.
- With DMEM_ERR_CHECK_EN:
  - Store to 0x42 and load from DEPTH*4.
  - Required for both: rsp_err = 1 and rsp_rdata = 0.
  - Required after the faulting store: a load from 0x40 shows memory unchanged.
  - Required without the macro: rsp_err = 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory answering CPU load/store requests
//
// One transaction in flight, WAIT_CYCLES wait states, byte-enable masked stores.
// Optional fault checking is compiled in with `define DMEM_ERR_CHECK_EN.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake
//   req_we_i               1 = store, 0 = load
//   req_addr_i             byte address
//   req_wdata_i, req_be_i  lane-aligned store data and byte enables
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_rdata_o            full-word load data (0 for stores and faults)
//   rsp_err_o              access faulted
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [3:0]        req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] mem [DEPTH];

    // The access executes either on the accepting edge (zero wait states) or
    // on the last WAIT edge; in the former case the request registers are not
    // yet loaded, so the access reads straight from the request inputs.
    logic              acc_from_req;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_fault;
    logic              acc_fire;
    logic              mem_we;

    assign acc_from_req = (state_q == ST_IDLE);
    assign acc_we       = acc_from_req ? req_we_i    : we_q;
    assign acc_addr     = acc_from_req ? req_addr_i  : addr_q;
    assign acc_wdata    = acc_from_req ? req_wdata_i : wdata_q;
    assign acc_be       = acc_from_req ? req_be_i    : be_q;
    assign acc_idx      = acc_addr[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign acc_fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);
`else
    // Byte offset and upper bits are ignored so accesses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr >> (IDX_W + 2)};
    assign acc_fault = 1'b0;
`endif

    // req_ready_o is gated by reset so it reads 0 while rst_ni is low.
    assign req_ready_o = rst_ni && (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        acc_fire = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ST_IDLE: acc_fire = req_valid_i && (WAIT_CYCLES == 0);
                ST_WAIT: acc_fire = (cnt_q == CNT_W'(1));
                default: acc_fire = 1'b0;
            endcase
        end
    end

    assign mem_we = acc_fire && acc_we && !acc_fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response data is captured once, on the access edge, and then held.
        if (acc_fire) begin
            rdata_d = (acc_we || acc_fault) ? 32'h0 : mem[acc_idx];
            err_d   = acc_fault;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WAIT_CYCLES = 2, instance B: WAIT_CYCLES = 0.
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
    );

    data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance A (sel=0) or B (sel=1); lat counts edges
    // from the cycle the request is presented until rsp_valid is seen.
    task automatic txn(input bit sel, input string tag, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata,
                       output logic err, output int lat);
        logic vld;
        logic rrdy;
        check({tag, "_ready_idle"}, sel ? b_req_ready : a_req_ready, 32'd1);
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
        end
        @(posedge clk); #1;
        if (sel) b_req_valid = 1'b0; else a_req_valid = 1'b0;
        check({tag, "_ready_busy"}, sel ? b_req_ready : a_req_ready, 32'd0);
        lat = 1;
        vld = sel ? b_rsp_valid : a_rsp_valid;
        while (!vld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            vld = sel ? b_rsp_valid : a_rsp_valid;
        end
        rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        err   = sel ? b_rsp_err : a_rsp_err;
        rrdy  = sel ? b_rsp_ready : a_rsp_ready;
        if (rrdy) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] held;
        logic        acc;

        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 1;

        // Reset values
        #2;
        check("rst_req_ready", a_req_ready, 32'd0);
        check("rst_rsp_valid", a_rsp_valid, 32'd0);
        check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        check("rst_rsp_err", a_rsp_err, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", a_req_ready, 32'd1);

        // Full-word store then load
        txn(0, "st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("st10_lat", lat, 32'd3);
        check("st10_rdata", rd, 32'd0);
        check("st10_err", er, 32'd0);
        txn(0, "ld10", 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("ld10_lat", lat, 32'd3);
        check("ld10_rdata", rd, 32'hDEADBEEF);

        // Byte enables
        txn(0, "st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        txn(0, "st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat);
        txn(0, "ld20", 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("ld20_rdata", rd, 32'h11BB33DD);

        // Backpressure
        a_rsp_ready = 1'b0;
        txn(0, "bp", 1'b0, 32'h20, 32'h0, 4'h0, held, er, lat);
        check("bp_lat", lat, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", a_rsp_valid, 32'd1);
            check("bp_rsp_rdata", a_rsp_rdata, 32'h11BB33DD);
            check("bp_req_ready", a_req_ready, 32'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", a_rsp_valid, 32'd0);
        check("bp_release_idle", a_req_ready, 32'd1);

        // Zero wait states on instance B
        txn(1, "b_st08", 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, rd, er, lat);
        check("b_st08_lat", lat, 32'd1);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h8; b_req_be = 4'h0;
        for (int i = 1; i <= 6; i++) begin
            acc = b_req_valid && b_req_ready;
            check("b2b_accept", acc, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check("b2b_rsp_valid", b_rsp_valid, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (b_rsp_valid) check("b2b_rdata", b_rsp_rdata, 32'h0BADCAFE);
        end
        b_req_valid = 1'b0;

        // Reset in the middle of a store
        txn(0, "st40", 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);
        txn(0, "st00", 1'b1, 32'h0, 32'h00001234, 4'hF, rd, er, lat);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h40; a_req_wdata = 32'h12345678; a_req_be = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("mid_wait_ready", a_req_ready, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", a_req_ready, 32'd0);
        check("mid_rst_valid", a_rsp_valid, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_valid_hold", a_rsp_valid, 32'd0);
            check("mid_rst_ready_hold", a_req_ready, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        txn(0, "ld40", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("ld40_after_rst", rd, 32'hCAFEF00D);

        // Fault checking
        txn(0, "st42", 1'b1, 32'h42, 32'h5A5A5A5A, 4'hF, rd, er, lat);
        check("st42_lat", lat, 32'd3);
        check("st42_rdata", rd, 32'd0);
`ifdef DMEM_ERR_CHECK_EN
        check("st42_err", er, 32'd1);
        txn(0, "ld400", 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        check("ld400_err", er, 32'd1);
        check("ld400_rdata", rd, 32'd0);
        txn(0, "ld40b", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("ld40b_rdata", rd, 32'hCAFEF00D);
        check("ld40b_err", er, 32'd0);
`else
        check("st42_err", er, 32'd0);
        txn(0, "ld40b", 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("ld40b_wrapped", rd, 32'h5A5A5A5A);
        check("ld40b_err", er, 32'd0);
        txn(0, "ld400", 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        check("ld400_wrapped", rd, 32'h00001234);
        check("ld400_err", er, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
